// File: rtl/golomb_rice_decode_if.sv
// Request, bit-stream and result bundle between a requester and the
// serial Golomb-Rice decoder.
interface golomb_rice_decode_if #(
  parameter int VAL_W = 32
);
  logic             start;
  logic [2:0]       k;
  logic             is_ac;
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic             busy;
  logic             done;
  logic             err;
  logic [VAL_W-1:0] val;
  logic             is_minus;
  logic [VAL_W-1:0] codeword_length;

  modport master (
    output start, k, is_ac, bit_in, bit_valid,
    input  bit_ready, busy, done, err, val, is_minus, codeword_length
  );

  modport slave (
    input  start, k, is_ac, bit_in, bit_valid,
    output bit_ready, busy, done, err, val, is_minus, codeword_length
  );
endinterface

// File: rtl/golomb_rice_decode.sv
// Serial Golomb-Rice decoder: takes q zeros, a '1', k remainder bits and an
// optional sign bit MSB-first, and reports value, sign and codeword length.
module golomb_rice_decode #(
  parameter int MAX_Q = 31,
  parameter int VAL_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  golomb_rice_decode_if.slave bus
);

  localparam int QW = $clog2(MAX_Q + 2);

  typedef enum logic [2:0] {
    IDLE,
    PREFIX,
    SUFFIX,
    SIGN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [QW-1:0]    qCnt_q, qCnt_d;
  logic [6:0]       rem_q, rem_d;
  logic [2:0]       remCnt_q, remCnt_d;
  logic [2:0]       k_q, k_d;
  logic             isAc_q, isAc_d;
  logic             sign_q, sign_d;
  logic             ovf_q, ovf_d;
  logic [VAL_W-1:0] valHold_q, valHold_d;
  logic [VAL_W-1:0] lenHold_q, lenHold_d;
  logic             minusHold_q, minusHold_d;

  logic             beat;
  logic             inStream;
  logic [VAL_W-1:0] valCalc;
  logic [VAL_W-1:0] lenCalc;
  logic             minusCalc;

  assign inStream = (state_q == PREFIX) || (state_q == SUFFIX) || (state_q == SIGN);
  assign beat     = bus.bit_valid && inStream;

  // Result of the codeword just finished; an overflowed prefix reports a
  // zero value and the fixed length of the bits actually consumed.
  always_comb begin
    valCalc   = '0;
    lenCalc   = VAL_W'(MAX_Q + 1);
    minusCalc = 1'b0;
    if (!ovf_q) begin
      valCalc   = (VAL_W'(qCnt_q) << k_q) | VAL_W'(rem_q);
      lenCalc   = VAL_W'(qCnt_q) + VAL_W'(1) + VAL_W'(k_q) + VAL_W'(isAc_q);
      minusCalc = sign_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      qCnt_q      <= '0;
      rem_q       <= '0;
      remCnt_q    <= '0;
      k_q         <= '0;
      isAc_q      <= 1'b0;
      sign_q      <= 1'b0;
      ovf_q       <= 1'b0;
      valHold_q   <= '0;
      lenHold_q   <= '0;
      minusHold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      qCnt_q      <= qCnt_d;
      rem_q       <= rem_d;
      remCnt_q    <= remCnt_d;
      k_q         <= k_d;
      isAc_q      <= isAc_d;
      sign_q      <= sign_d;
      ovf_q       <= ovf_d;
      valHold_q   <= valHold_d;
      lenHold_q   <= lenHold_d;
      minusHold_q <= minusHold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    qCnt_d      = qCnt_q;
    rem_d       = rem_q;
    remCnt_d    = remCnt_q;
    k_d         = k_q;
    isAc_d      = isAc_q;
    sign_d      = sign_q;
    ovf_d       = ovf_q;
    valHold_d   = valHold_q;
    lenHold_d   = lenHold_q;
    minusHold_d = minusHold_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          k_d     = bus.k;
          isAc_d  = bus.is_ac;
          qCnt_d  = '0;
          rem_d   = '0;
          sign_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = PREFIX;
        end
      end
      PREFIX: begin
        if (beat) begin
          if (!bus.bit_in) begin
            if (qCnt_q == QW'(MAX_Q)) begin
              ovf_d   = 1'b1;
              state_d = DONE;
            end else begin
              qCnt_d = qCnt_q + QW'(1);
            end
          end else if (k_q != 3'd0) begin
            remCnt_d = k_q;
            state_d  = SUFFIX;
          end else if (isAc_q) begin
            state_d = SIGN;
          end else begin
            state_d = DONE;
          end
        end
      end
      SUFFIX: begin
        if (beat) begin
          rem_d    = {rem_q[5:0], bus.bit_in};
          remCnt_d = remCnt_q - 3'd1;
          if (remCnt_q == 3'd1) begin
            state_d = isAc_q ? SIGN : DONE;
          end
        end
      end
      SIGN: begin
        if (beat) begin
          sign_d  = bus.bit_in;
          state_d = DONE;
        end
      end
      DONE: begin
        valHold_d   = valCalc;
        lenHold_d   = lenCalc;
        minusHold_d = minusCalc;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Results show live during DONE and are held afterwards.
  always_comb begin
    bus.bit_ready       = inStream;
    bus.busy            = inStream;
    bus.done            = (state_q == DONE);
    bus.err             = (state_q == DONE) && ovf_q;
    bus.val             = valHold_q;
    bus.is_minus        = minusHold_q;
    bus.codeword_length = lenHold_q;
    if (state_q == DONE) begin
      bus.val             = valCalc;
      bus.is_minus        = minusCalc;
      bus.codeword_length = lenCalc;
    end
  end

endmodule

// File: tb/tb_golomb_rice_decode.sv
// Directed and table-driven checks for golomb_rice_decode, with a small
// encoder model for round-trip words.
module tb_golomb_rice_decode;

  localparam int MAX_Q = 31;
  localparam int VAL_W = 32;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  golomb_rice_decode_if #(.VAL_W(VAL_W)) bus ();

  golomb_rice_decode #(
    .MAX_Q(MAX_Q),
    .VAL_W(VAL_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [2:0]  k;
    logic        ac;
    logic [39:0] bits;
    int          n;
    int          stallAfter;
    int          stallLen;
    bit          poke;
    logic [31:0] expVal;
    logic        expMinus;
    logic [31:0] expLen;
    logic        expErr;
    int          expDone;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Issues one start, then streams n bits (first bit at bits[n-1]) with an
  // optional bubble of stallLen cycles once stallAfter bits have been taken.
  task automatic applyStimulus(input logic [2:0] kIn, input logic acIn, input logic [39:0] bits,
                               input int n, input int stallAfter, input int stallLen, input bit poke,
                               output int doneCycle, output logic [VAL_W-1:0] gotVal,
                               output logic gotMinus, output logic [VAL_W-1:0] gotLen,
                               output logic gotErr);
    int idx;
    int stallCnt;
    idx = 0;
    stallCnt = 0;
    doneCycle = -1;
    gotVal = '0;
    gotMinus = 1'b0;
    gotLen = '0;
    gotErr = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.k = kIn;
    bus.is_ac = acIn;
    bus.bit_valid = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (poke && c == 2) begin
        bus.start = 1'b1;
        bus.k = 3'd7;
        bus.is_ac = ~acIn;
      end
      if (bus.done) begin
        doneCycle = c;
        gotVal = bus.val;
        gotMinus = bus.is_minus;
        gotLen = bus.codeword_length;
        gotErr = bus.err;
        bus.bit_valid = 1'b0;
        break;
      end
      if (idx == stallAfter && stallCnt < stallLen) begin
        bus.bit_valid = 1'b0;
        checkOutput("stall bit_ready", 64'(bus.bit_ready), 64'd1);
        stallCnt++;
      end else if (idx < n) begin
        bus.bit_valid = 1'b1;
        bus.bit_in = bits[n-1-idx];
        if (bus.bit_ready) idx++;
      end else begin
        bus.bit_valid = 1'b0;
      end
    end
    bus.bit_valid = 1'b0;
  endtask

  initial begin
    int               dc;
    logic [VAL_W-1:0] gv;
    logic             gm;
    logic [VAL_W-1:0] gl;
    logic             ge;
    int               firstDone;

    vecs[0] = '{3'd0, 1'b0, 40'b001,          3,  0, 0, 1'b0, 32'd2,   1'b0, 32'd3,  1'b0, 4};
    vecs[1] = '{3'd2, 1'b1, 40'b001011,       6,  0, 0, 1'b1, 32'd9,   1'b1, 32'd6,  1'b0, 7};
    vecs[2] = '{3'd2, 1'b1, 40'b001010,       6,  0, 0, 1'b0, 32'd9,   1'b0, 32'd6,  1'b0, 7};
    vecs[3] = '{3'd3, 1'b1, 40'b11010,        5,  2, 3, 1'b0, 32'd5,   1'b0, 32'd5,  1'b0, 9};
    vecs[4] = '{3'd0, 1'b0, 40'h0,            32, 0, 0, 1'b0, 32'd0,   1'b0, 32'd32, 1'b1, 33};
    vecs[5] = '{3'd0, 1'b0, 40'h1,            32, 0, 0, 1'b0, 32'd31,  1'b0, 32'd32, 1'b0, 33};
    vecs[6] = '{3'd7, 1'b1, 40'b000111111111, 12, 0, 0, 1'b0, 32'd511, 1'b1, 32'd12, 1'b0, 13};
    vecs[7] = '{3'd0, 1'b1, 40'b011,          3,  0, 0, 1'b0, 32'd1,   1'b1, 32'd3,  1'b0, 4};
    vecs[8] = '{3'd5, 1'b0, 40'b110110,       6,  0, 0, 1'b0, 32'd22,  1'b0, 32'd6,  1'b0, 7};
    vecs[9] = '{3'd1, 1'b1, 40'b0000100,      7,  0, 0, 1'b0, 32'd8,   1'b0, 32'd7,  1'b0, 8};

    bus.start = 1'b1;
    bus.k = 3'd5;
    bus.is_ac = 1'b1;
    bus.bit_in = 1'b0;
    bus.bit_valid = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset bit_ready", 64'(bus.bit_ready), 64'd0);
    checkOutput("reset busy", 64'(bus.busy), 64'd0);
    checkOutput("reset done", 64'(bus.done), 64'd0);
    checkOutput("reset err", 64'(bus.err), 64'd0);
    checkOutput("reset val", 64'(bus.val), 64'd0);
    checkOutput("reset is_minus", 64'(bus.is_minus), 64'd0);
    checkOutput("reset length", 64'(bus.codeword_length), 64'd0);
    reset = 1'b0;
    bus.start = 1'b0;
    bus.bit_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle after reset bit_ready", 64'(bus.bit_ready), 64'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].k, vecs[i].ac, vecs[i].bits, vecs[i].n, vecs[i].stallAfter,
                    vecs[i].stallLen, vecs[i].poke, dc, gv, gm, gl, ge);
      checkOutput($sformatf("v%0d done cycle", i), 64'(dc), 64'(vecs[i].expDone));
      checkOutput($sformatf("v%0d val", i), 64'(gv), 64'(vecs[i].expVal));
      checkOutput($sformatf("v%0d is_minus", i), 64'(gm), 64'(vecs[i].expMinus));
      checkOutput($sformatf("v%0d length", i), 64'(gl), 64'(vecs[i].expLen));
      checkOutput($sformatf("v%0d err", i), 64'(ge), 64'(vecs[i].expErr));
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d done low after", i), 64'(bus.done), 64'd0);
      checkOutput($sformatf("v%0d busy low after", i), 64'(bus.busy), 64'd0);
      checkOutput($sformatf("v%0d err low after", i), 64'(bus.err), 64'd0);
      checkOutput($sformatf("v%0d val held", i), 64'(bus.val), 64'(vecs[i].expVal));
    end

    // Reset in the middle of the remainder bits.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.k = 3'd2;
    bus.is_ac = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("midreset busy before", 64'(bus.busy), 64'd1);
    bus.bit_valid = 1'b1;
    bus.bit_in = 1'b1;
    @(posedge clk); #1;
    bus.bit_in = 1'b0;
    @(posedge clk); #1;
    bus.bit_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midreset bit_ready", 64'(bus.bit_ready), 64'd0);
    checkOutput("midreset busy", 64'(bus.busy), 64'd0);
    checkOutput("midreset done", 64'(bus.done), 64'd0);
    checkOutput("midreset val", 64'(bus.val), 64'd0);
    checkOutput("midreset length", 64'(bus.codeword_length), 64'd0);
    @(posedge clk); #1;
    checkOutput("midreset no done", 64'(bus.done), 64'd0);
    applyStimulus(3'd2, 1'b0, 40'b111, 3, 0, 0, 1'b0, dc, gv, gm, gl, ge);
    checkOutput("post-reset done cycle", 64'(dc), 64'd4);
    checkOutput("post-reset val", 64'(gv), 64'd3);
    checkOutput("post-reset length", 64'(gl), 64'd3);

    // Back-to-back words, with a stray start in the DONE cycle.
    applyStimulus(3'd1, 1'b0, 40'b10, 2, 0, 0, 1'b0, dc, gv, gm, gl, ge);
    firstDone = cyc;
    checkOutput("b2b first done cycle", 64'(dc), 64'd3);
    checkOutput("b2b first val", 64'(gv), 64'd0);
    checkOutput("b2b first length", 64'(gl), 64'd2);
    bus.start = 1'b1;
    bus.k = 3'd7;
    bus.is_ac = 1'b1;
    applyStimulus(3'd1, 1'b0, 40'b011, 3, 0, 0, 1'b0, dc, gv, gm, gl, ge);
    checkOutput("b2b second val", 64'(gv), 64'd3);
    checkOutput("b2b second length", 64'(gl), 64'd3);
    checkOutput("b2b done spacing", 64'(cyc - firstDone), 64'd5);

    // Round trip through an encoder model with bubbles.
    for (int t = 0; t < 16; t++) begin
      logic [2:0]  rk;
      logic        rac;
      logic        rneg;
      int          rq;
      logic [31:0] rv;
      logic [39:0] rbits;
      int          rn;
      int          rsa;
      int          rsl;
      rk = 3'($urandom_range(0, 7));
      rac = 1'($urandom_range(0, 1));
      rneg = rac ? 1'($urandom_range(0, 1)) : 1'b0;
      rq = $urandom_range(0, MAX_Q);
      rv = (32'(rq) << rk) | (32'($urandom) & ((32'd1 << rk) - 32'd1));
      rbits = '0;
      rn = 0;
      for (int z = 0; z < rq; z++) begin
        rbits = {rbits[38:0], 1'b0};
        rn++;
      end
      rbits = {rbits[38:0], 1'b1};
      rn++;
      for (int b = 32'(rk) - 1; b >= 0; b--) begin
        rbits = {rbits[38:0], rv[b]};
        rn++;
      end
      if (rac) begin
        rbits = {rbits[38:0], rneg};
        rn++;
      end
      rsa = $urandom_range(0, rn - 1);
      rsl = $urandom_range(0, 3);
      applyStimulus(rk, rac, rbits, rn, rsa, rsl, 1'b0, dc, gv, gm, gl, ge);
      checkOutput($sformatf("rt%0d done cycle", t), 64'(dc), 64'(rn + 1 + rsl));
      checkOutput($sformatf("rt%0d val", t), 64'(gv), 64'(rv));
      checkOutput($sformatf("rt%0d is_minus", t), 64'(gm), 64'(rneg));
      checkOutput($sformatf("rt%0d length", t), 64'(gl), 64'(rn));
      checkOutput($sformatf("rt%0d err", t), 64'(ge), 64'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
